oka_divider_16by8: RTL and testbench



---
 rtl/oka_divider_16by8_pkg.sv | 14 +
 rtl/oka_divider_16by8_if.sv | 24 ++
 rtl/oka_divider_16by8_step.sv | 29 ++
 rtl/oka_divider_16by8.sv | 98 +++++++++
 tb/tb_oka_divider_16by8.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oka_divider_16by8_pkg.sv
// Shared constants and FSM encoding for the 16-by-8 sequential restoring divider.
package oka_div_pkg;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/oka_divider_16by8_if.sv
// Start/busy/valid handshake bundle between a requester (master) and the divider (slave).
interface oka_div_if;
  import oka_div_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          valid;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, valid, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/oka_divider_16by8_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module oka_div_step
  import oka_div_pkg::*;
(
  input  logic [VW-1:0] pr,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] pr_next,
  output logic          qbit
);

  logic [VW:0] shifted_s;
  logic [VW:0] diff_s;

  assign shifted_s = {pr, din};
  assign diff_s    = shifted_s - {1'b0, divisor};

  // Restoring decision; with a nonzero divisor the result is below it, so the top bit is always zero
  always_comb begin
    if (shifted_s >= {1'b0, divisor}) begin
      pr_next = diff_s[VW-1:0];
      qbit    = 1'b1;
    end else begin
      pr_next = shifted_s[VW-1:0];
      qbit    = 1'b0;
    end
  end

endmodule

// File: rtl/oka_divider_16by8.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
module oka_divider_16by8
  import oka_div_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  oka_div_if.slave bus
);

  div_state_e    state_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] divisor_r;
  logic [VW-1:0] pr_r;
  logic          busy_r;
  logic          valid_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          div_zero_r;
  logic [VW-1:0] pr_next_s;
  logic          qbit_s;

  oka_div_step u_step (
    .pr      (pr_r),
    .din     (dvd_r[DW-1]),
    .divisor (divisor_r),
    .pr_next (pr_next_s),
    .qbit    (qbit_s)
  );

  // Control FSM plus datapath; dvd_r shifts dividend bits out and quotient bits in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      dvd_r       <= '0;
      divisor_r   <= '0;
      pr_r        <= '0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      busy_r  <= (state_r == RUN);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            dvd_r     <= bus.dividend;
            divisor_r <= bus.divisor;
            pr_r      <= '0;
            cnt_r     <= CW'(DW);
            state_r   <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          pr_r  <= pr_next_s;
          dvd_r <= {dvd_r[DW-2:0], qbit_s};
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          quotient_r  <= dvd_r;
          remainder_r <= pr_r;
          div_zero_r  <= (divisor_r == {VW{1'b0}});
          valid_r     <= 1'b1;
          // Accepting here keeps back-to-back throughput at one division per DW+1 cycles
          if (bus.start) begin
            dvd_r     <= bus.dividend;
            divisor_r <= bus.divisor;
            pr_r      <= '0;
            cnt_r     <= CW'(DW);
            state_r   <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.valid     = valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_oka_divider_16by8.sv
// Self-checking bench for oka_divider_16by8: arithmetic reference model plus directed literal cases.
module tb_oka_divider_16by8;
  import oka_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  oka_div_if bus ();

  oka_divider_16by8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    int done_at;
    int dd;
    int dv;
  } txn_t;

  txn_t        pend[$];
  logic        e_valid = 1'b0;
  logic        e_busy  = 1'b0;
  logic [15:0] e_q     = 16'h0000;
  logic [7:0]  e_r     = 8'h00;
  logic        e_dz    = 1'b0;
  int          e_dd    = 0;
  int          e_dv    = 1;
  int          next_free = 0;
  int          last_acc  = -100;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a request is taken whenever the divider is not inside a 17-cycle job window
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        e_valid = 1'b0; e_busy = 1'b0;
        e_q = 16'h0000; e_r = 8'h00; e_dz = 1'b0;
        next_free = 0; last_acc = -100;
      end else begin
        int   e;
        txn_t t;
        e = cyc + 1;
        if (bus.start && e >= next_free) begin
          t.done_at = e + 17;
          t.dd = int'(bus.dividend);
          t.dv = int'(bus.divisor);
          pend.push_back(t);
          last_acc  = e;
          next_free = e + 17;
        end
        e_valid = 1'b0;
        if (pend.size() > 0 && pend[0].done_at == e) begin
          t = pend.pop_front();
          e_valid = 1'b1;
          e_dd = t.dd;
          e_dv = t.dv;
          if (t.dv == 0) begin
            e_q = 16'hFFFF; e_r = t.dd[7:0]; e_dz = 1'b1;
          end else begin
            e_q = 16'(t.dd / t.dv); e_r = 8'(t.dd % t.dv); e_dz = 1'b0;
          end
        end
        e_busy = (e >= last_acc + 1) && (e <= last_acc + 16);
      end
    end
  end

  // Compare process: every output every cycle, plus the arithmetic identity on each result
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("valid", 32'(bus.valid), 32'(e_valid));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("quotient", 32'(bus.quotient), 32'(e_q));
        check("remainder", 32'(bus.remainder), 32'(e_r));
        check("div_zero", 32'(bus.div_zero), 32'(e_dz));
        if (bus.valid === 1'b1 && e_valid && e_dv != 0) begin
          check("recon", 32'(int'(bus.quotient) * e_dv + int'(bus.remainder)), 32'(e_dd));
          check("rem_lt_div", 32'(int'(bus.remainder) < e_dv), 32'd1);
        end
      end
    end
  end

  task automatic run_one(input logic [15:0] dd, input logic [7:0] dv, input logic [15:0] xq,
                         input logic [7:0] xr, input logic xdz, input string nm);
    int acc;
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
    acc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        check({nm, "_latency"}, 32'(cyc - acc), 32'd17);
        check({nm, "_q"}, 32'(bus.quotient), 32'(xq));
        check({nm, "_r"}, 32'(bus.remainder), 32'(xr));
        check({nm, "_dz"}, 32'(bus.div_zero), 32'(xdz));
      end
    end
    if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic back_to_back();
    int acc;
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'h0AC8; bus.divisor = 8'h0F;
    acc = cyc + 1;
    @(negedge clk);
    bus.dividend = 16'h0064; bus.divisor = 8'h0A;
    while (cyc < acc + 45) begin
      @(negedge clk);
      if (cyc == acc + 17) begin
        bus.start = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
      end else if (cyc == acc + 22) begin
        bus.start = 1'b1;
      end else if (cyc == acc + 23) begin
        bus.start = 1'b0;
      end
      if (bus.valid === 1'b1) begin
        nvalid++;
        if (nvalid == 1) begin
          check("b2b_first_at", 32'(cyc - acc), 32'd17);
          check("b2b_first_q", 32'(bus.quotient), 32'h00B8);
          check("b2b_first_r", 32'(bus.remainder), 32'h00);
        end else if (nvalid == 2) begin
          check("b2b_second_at", 32'(cyc - acc), 32'd34);
          check("b2b_second_q", 32'(bus.quotient), 32'h000A);
          check("b2b_second_r", 32'(bus.remainder), 32'h00);
        end
      end
    end
    check("b2b_valid_count", 32'(nvalid), 32'd2);
  endtask

  task automatic reset_mid_run();
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'h0AC8; bus.divisor = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nvalid++;
    end
    check("rst_no_valid", 32'(nvalid), 32'd0);
    run_one(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, "after_rst");
  endtask

  function automatic logic [15:0] rand_dividend();
    case ($urandom_range(0, 3))
      0: rand_dividend = 16'hFFFF;
      1: rand_dividend = 16'($urandom_range(0, 255));
      default: rand_dividend = 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rand_divisor();
    case ($urandom_range(0, 7))
      0: rand_divisor = 8'h00;
      1: rand_divisor = 8'hFF;
      2: rand_divisor = 8'h01;
      default: rand_divisor = 8'($urandom);
    endcase
  endfunction

  task automatic random_sweep();
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.start = 1'b1;
      repeat ($urandom_range(1, 20)) begin
        bus.dividend = rand_dividend();
        bus.divisor  = rand_divisor();
        @(negedge clk);
      end
      bus.start = 1'b0;
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_q", 32'(bus.quotient), 32'd0);
    check("reset_r", 32'(bus.remainder), 32'd0);
    check("reset_dz", 32'(bus.div_zero), 32'd0);
    #2 rst_n = 1'b1;

    run_one(16'h0AC8, 8'h0F, 16'h00B8, 8'h00, 1'b0, "b8x0f");
    run_one(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, "d1000by7");
    run_one(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, "ffffbyff");
    run_one(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, "ffffby1");
    run_one(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, "divzero");
    back_to_back();
    reset_mid_run();
    random_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
